// File: rtl/adder_result_checker.sv
// adder_result_checker
//   Self-checking consumer for a registered prefix-adder wrapper. It taps the operand stream
//   going into the wrapper and delays it by the wrapper latency. It then compares the golden
//   a+b with the wrapper's {cout,sum}, counts compares and mismatches, and keeps the first
//   failing vector.
//
// Ports
//   clk        rising-edge clock shared with the wrapper
//   rst_n      synchronous active-low reset
//   start      one-cycle pulse: clear stats and begin a run (ignored while busy)
//   num_vec    vectors to check in this run, sampled on an accepted start
//   in_valid   in_a/in_b are being driven into the wrapper this cycle
//   in_a/in_b  operands, same cycle as the wrapper input
//   dut_sum    wrapper sum output
//   dut_cout   wrapper carry output
//   busy       run in progress (RUN or DRAIN)
//   done       run finished, stats held
//   pass       done with no mismatches
//   chk_cnt    vectors compared this run
//   err_cnt    mismatches this run, saturating
//   fail_a/b   operands of the first mismatch
//   fail_sum   {dut_cout,dut_sum} of the first mismatch
module adder_result_checker #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH:0]   fail_sum
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic [WIDTH:0]   fail_sum_q, fail_sum_d;

  // Operand delay line, aligned with the wrapper pipeline.
  logic [LATENCY-1:0]            v_q, v_d;
  logic [LATENCY-1:0][WIDTH-1:0] a_q, a_d;
  logic [LATENCY-1:0][WIDTH-1:0] b_q, b_d;

  logic           accepting;
  logic           start_ok;
  logic           cmp_valid;
  logic           mismatch;
  logic [WIDTH:0] exp_sum;
  logic [WIDTH:0] got_sum;

  always_comb begin
    accepting = (state_q == StRun) && (acc_cnt_q < num_vec_q);
    start_ok  = start && ((state_q == StIdle) || (state_q == StDone));
    cmp_valid = v_q[LATENCY-1];
    exp_sum   = {1'b0, a_q[LATENCY-1]} + {1'b0, b_q[LATENCY-1]};
    got_sum   = {dut_cout, dut_sum};
    mismatch  = cmp_valid && (got_sum != exp_sum);
  end

  always_comb begin
    state_d    = state_q;
    num_vec_d  = num_vec_q;
    acc_cnt_d  = acc_cnt_q;
    chk_cnt_d  = chk_cnt_q;
    err_cnt_d  = err_cnt_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_sum_d = fail_sum_q;

    v_d[0] = in_valid && accepting;
    a_d[0] = in_a;
    b_d[0] = in_b;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      v_d[i] = v_q[i-1];
      a_d[i] = a_q[i-1];
      b_d[i] = b_q[i-1];
    end

    if (in_valid && accepting) begin
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end

    if (cmp_valid) begin
      chk_cnt_d = chk_cnt_q + CNT_W'(1);
      if (mismatch) begin
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        // Only the first failing vector is kept.
        if (err_cnt_q == '0) begin
          fail_a_d   = a_q[LATENCY-1];
          fail_b_d   = b_q[LATENCY-1];
          fail_sum_d = got_sum;
        end
      end
    end

    unique case (state_q)
      StIdle:  ;
      StRun:   if (acc_cnt_q == num_vec_q) state_d = StDrain;
      StDrain: if (v_q == '0) state_d = StDone;
      StDone:  ;
      default: state_d = StIdle;
    endcase

    // A new run wipes everything, including any residue in the delay line.
    if (start_ok) begin
      state_d    = StRun;
      num_vec_d  = num_vec;
      acc_cnt_d  = '0;
      chk_cnt_d  = '0;
      err_cnt_d  = '0;
      fail_a_d   = '0;
      fail_b_d   = '0;
      fail_sum_d = '0;
      v_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      num_vec_q  <= '0;
      acc_cnt_q  <= '0;
      chk_cnt_q  <= '0;
      err_cnt_q  <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_sum_q <= '0;
      v_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      num_vec_q  <= num_vec_d;
      acc_cnt_q  <= acc_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
      err_cnt_q  <= err_cnt_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_sum_q <= fail_sum_d;
      v_q        <= v_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  always_comb begin
    busy     = (state_q == StRun) || (state_q == StDrain);
    done     = (state_q == StDone);
    pass     = done && (err_cnt_q == '0);
    chk_cnt  = chk_cnt_q;
    err_cnt  = err_cnt_q;
    fail_a   = fail_a_q;
    fail_b   = fail_b_q;
    fail_sum = fail_sum_q;
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker. A behavioural two-stage registered 4-bit adder stands in
// for the wrapper. It can corrupt sum[0] for 3+5 and force cout low for 15+15. Each run
// pushes its expected final stats into a queue. A monitor pops that queue and compares
// on every rising edge of done.
module tb_adder_result_checker;

  localparam int unsigned W  = 4;
  localparam int unsigned L  = 2;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_vec;
  logic          in_valid;
  logic [W-1:0]  in_a, in_b;
  logic [W-1:0]  dut_sum;
  logic          dut_cout;
  logic          busy, done, pass;
  logic [CW-1:0] chk_cnt, err_cnt;
  logic [W-1:0]  fail_a, fail_b;
  logic [W:0]    fail_sum;

  always #5 clk = ~clk;

  adder_result_checker #(
    .WIDTH  (W),
    .LATENCY(L),
    .CNT_W  (CW)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .num_vec (num_vec),
    .in_valid(in_valid),
    .in_a    (in_a),
    .in_b    (in_b),
    .dut_sum (dut_sum),
    .dut_cout(dut_cout),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .chk_cnt (chk_cnt),
    .err_cnt (err_cnt),
    .fail_a  (fail_a),
    .fail_b  (fail_b),
    .fail_sum(fail_sum)
  );

  // Wrapper model: input register then output register.
  logic         fault_sum0 = 1'b0;
  logic         fault_cout0 = 1'b0;
  logic [W-1:0] ra = '0, rb = '0;

  function automatic logic [W:0] wrap_out(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (fault_sum0 && a == 4'd3 && b == 4'd5) s[0] = ~s[0];
    if (fault_cout0 && a == 4'd15 && b == 4'd15) s[W] = 1'b0;
    return s;
  endfunction

  always @(posedge clk) begin
    ra <= in_a;
    rb <= in_b;
    {dut_cout, dut_sum} <= wrap_out(ra, rb);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  typedef struct {
    int id;
    int chk;
    int err;
    int pas;
    int fa;
    int fb;
    int fs;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   run_id = 0;

  task automatic expect_run(input int chk, input int err, input int pas,
                            input int fa, input int fb, input int fs);
    exp_t e;
    e = '{id: run_id, chk: chk, err: err, pas: pas, fa: fa, fb: fb, fs: fs};
    sb_q.push_back(e);
    run_id++;
  endtask

  // Monitor: final stats are compared when done rises.
  logic done_d = 1'b0;
  always @(negedge clk) begin
    if (done && !done_d) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done rose with no run queued, chk_cnt=%0d", chk_cnt);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("run%0d_chk_cnt", mon_e.id), 32'(chk_cnt), mon_e.chk);
        check($sformatf("run%0d_err_cnt", mon_e.id), 32'(err_cnt), mon_e.err);
        check($sformatf("run%0d_pass", mon_e.id), 32'(pass), mon_e.pas);
        check($sformatf("run%0d_fail_a", mon_e.id), 32'(fail_a), mon_e.fa);
        check($sformatf("run%0d_fail_b", mon_e.id), 32'(fail_b), mon_e.fb);
        check($sformatf("run%0d_fail_sum", mon_e.id), 32'(fail_sum), mon_e.fs);
      end
    end
    done_d <= done;
  end

  task automatic start_run(input int n);
    num_vec = CW'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s: done=%0d, required 1 within %0d cycles", name, done, budget);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_chk_cnt"}, 32'(chk_cnt), 0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 0);
    check({tag, "_fail_a"}, 32'(fail_a), 0);
    check({tag, "_fail_b"}, 32'(fail_b), 0);
    check({tag, "_fail_sum"}, 32'(fail_sum), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hit;
    rst_n    = 1'b0;
    start    = 1'b0;
    num_vec  = '0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exhaustive, correct wrapper.
    expect_run(256, 0, 1, 0, 0, 0);
    start_run(256);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) drive(1'b1, 4'(a), 4'(b));
    end
    in_valid = 1'b0;
    wait_done("exhaustive_done", 20);

    // sum[0] flipped for 3+5 only.
    fault_sum0 = 1'b1;
    expect_run(4, 1, 0, 3, 5, 5'b01001);
    start_run(4);
    drive(1'b1, 4'd1, 4'd2);
    drive(1'b1, 4'd3, 4'd5);
    drive(1'b1, 4'd5, 4'd3);
    drive(1'b1, 4'd15, 4'd1);
    in_valid = 1'b0;
    wait_done("sumfault_done", 20);
    fault_sum0 = 1'b0;

    // Gapped stream; the extra valid cycles would mismatch if they were compared.
    expect_run(10, 0, 1, 0, 0, 0);
    start_run(10);
    for (int i = 0; i < 20; i++) drive((i % 2) == 0, 4'(i), 4'(i * 3));
    fault_cout0 = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd15, 4'd15);
    in_valid = 1'b0;
    wait_done("gapped_done", 20);
    fault_cout0 = 1'b0;

    // Carry edge: 15+15 with cout forced low.
    fault_cout0 = 1'b1;
    expect_run(2, 1, 0, 15, 15, 5'b01110);
    start_run(2);
    drive(1'b1, 4'd15, 4'd15);
    drive(1'b1, 4'd2, 4'd2);
    in_valid = 1'b0;
    wait_done("carry_done", 20);

    // Two different faults: the first one is the one captured.
    fault_sum0 = 1'b1;
    expect_run(3, 2, 0, 15, 15, 5'b01110);
    start_run(3);
    drive(1'b1, 4'd15, 4'd15);
    drive(1'b1, 4'd3, 4'd5);
    drive(1'b1, 4'd1, 4'd1);
    in_valid = 1'b0;
    wait_done("first_capture_done", 20);
    fault_sum0  = 1'b0;
    fault_cout0 = 1'b0;

    // num_vec=0 from DONE: stats cleared at once, done three cycles after start.
    expect_run(0, 0, 1, 0, 0, 0);
    start_run(0);
    check("zero_c1_busy", 32'(busy), 1);
    check("zero_c1_done", 32'(done), 0);
    check("zero_c1_chk_cnt", 32'(chk_cnt), 0);
    check("zero_c1_err_cnt", 32'(err_cnt), 0);
    check("zero_c1_fail_a", 32'(fail_a), 0);
    check("zero_c1_fail_b", 32'(fail_b), 0);
    check("zero_c1_fail_sum", 32'(fail_sum), 0);
    @(posedge clk); #1;
    check("zero_c2_busy", 32'(busy), 1);
    check("zero_c2_done", 32'(done), 0);
    @(posedge clk); #1;
    check("zero_c3_done", 32'(done), 1);
    check("zero_c3_pass", 32'(pass), 1);

    // start while busy is ignored; honoring it would need 100 vectors and never finish.
    expect_run(4, 0, 1, 0, 0, 0);
    start_run(4);
    drive(1'b1, 4'd1, 4'd1);
    num_vec = CW'(100);
    start   = 1'b1;
    drive(1'b1, 4'd2, 4'd3);
    start   = 1'b0;
    drive(1'b1, 4'd4, 4'd5);
    drive(1'b1, 4'd6, 4'd7);
    in_valid = 1'b0;
    wait_done("busy_start_done", 20);

    // Reset mid-run once five compares have landed.
    fault_sum0 = 1'b1;
    start_run(20);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      drive(1'b1, 4'(i), 4'd5);
      if (chk_cnt == CW'(5)) hit = 1'b1;
    end
    check("midrun_reached_5", 32'(hit), 1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_a     = 4'd3;
    in_b     = 4'd5;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check_all_zero("midrun_reset");
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_chk_cnt", 32'(chk_cnt), 0);
    check("post_reset_err_cnt", 32'(err_cnt), 0);
    check("post_reset_busy", 32'(busy), 0);
    fault_sum0 = 1'b0;

    // A clean run after reset still works.
    expect_run(3, 0, 1, 0, 0, 0);
    start_run(3);
    drive(1'b1, 4'd9, 4'd8);
    drive(1'b1, 4'd0, 4'd0);
    drive(1'b1, 4'd12, 4'd4);
    in_valid = 1'b0;
    wait_done("after_reset_done", 20);
    @(negedge clk);
    @(negedge clk);

    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
